// File: rtl/e203_ifu_jalr_sched_pkg.sv
// Shared defines for the IFU jalr scheduler: FSM state encodings and
// the register-index constants used to classify jalr sources.
package e203_ifu_jalr_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEP_X1  = 3'd1,
        ST_DEP_XN  = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4
    } jalr_state_e;

    localparam logic [4:0] RIDX_X0 = 5'd0;
    localparam logic [4:0] RIDX_X1 = 5'd1;

endpackage

// File: rtl/e203_ifu_jalr_sched_add.sv
// Single 32-bit op1+imm adder shared by every prediction path.
module e203_ifu_jalr_sched_add (
    input  logic [31:0] op1,
    input  logic [31:0] imm,
    output logic [31:0] sum
);

    // 32-bit wrap-around add
    assign sum = op1 + imm;

endmodule

// File: rtl/e203_ifu_jalr_sched.sv
// IFU branch/jump target predictor with jalr operand scheduling.
// jal/bxx/non-branch and jalr x0/x1 resolve in the fetch cycle when
// possible; jalr with another rs1 waits for the pipe to drain and then
// borrows the shared RF read port for one cycle.
// Optional feature: define E203_IFU_BTFN_EN to predict backward bxx taken.
module e203_ifu_jalr_sched
    import e203_ifu_jalr_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_valid,
    output logic        f_ready,
    input  logic [31:0] f_pc,
    input  logic        dec_bjp,
    input  logic        dec_jal,
    input  logic        dec_jalr,
    input  logic        dec_bxx,
    input  logic [4:0]  dec_jalr_rs1idx,
    input  logic [31:0] dec_bjp_imm,
    input  logic        oitf_empty,
    input  logic        ir_empty,
    input  logic        ir_rdwen,
    input  logic [4:0]  ir_rdidx,
    input  logic        ir_rs1en,
    input  logic [31:0] rf_x1,
    input  logic [31:0] rf_xn_rdata,
    output logic        rf_rd_req,
    output logic [4:0]  rf_rd_idx,
    output logic        prdt_taken,
    output logic [31:0] prdt_pc,
    input  logic        flush_req
);

    jalr_state_e state, state_nxt;
    logic [4:0]  cap_rs1;
    logic [31:0] cap_imm;
    logic [31:0] xn_q;
    logic        data_ph;   // 0: capturing rdata, 1: presenting result

    logic        x1_dep;
    logic        bxx_tk;
    logic        rdy, tk, req;
    logic [31:0] op1, imm, sum;

    assign x1_dep = ~oitf_empty | (ir_rdwen & (ir_rdidx == RIDX_X1));

`ifdef E203_IFU_BTFN_EN
    assign bxx_tk = dec_bjp_imm[31];
`else
    assign bxx_tk = 1'b0;
`endif

    // next-state, operand selection and handshake decode
    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        tk        = 1'b0;
        req       = 1'b0;
        op1       = f_pc;
        imm       = dec_bjp_imm;
        case (state)
            ST_IDLE: begin
                if (f_valid && !flush_req) begin
                    if (dec_bjp && dec_jal) begin
                        rdy = 1'b1;
                        tk  = 1'b1;
                    end else if (dec_bjp && dec_bxx) begin
                        rdy = 1'b1;
                        tk  = bxx_tk;
                        if (!bxx_tk) imm = 32'd4;
                    end else if (dec_bjp && dec_jalr) begin
                        tk = 1'b1;
                        if (dec_jalr_rs1idx == RIDX_X0) begin
                            op1 = 32'd0;
                            rdy = 1'b1;
                        end else if (dec_jalr_rs1idx == RIDX_X1) begin
                            op1 = rf_x1;
                            if (x1_dep) state_nxt = ST_DEP_X1;
                            else        rdy = 1'b1;
                        end else begin
                            state_nxt = ST_DEP_XN;
                        end
                    end else begin
                        rdy = 1'b1;
                    end
                end
            end
            ST_DEP_X1: begin
                tk  = 1'b1;
                op1 = rf_x1;
                imm = cap_imm;
                if (flush_req) begin
                    state_nxt = ST_IDLE;
                end else if (!x1_dep) begin
                    rdy       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DEP_XN: begin
                if (flush_req)                   state_nxt = ST_IDLE;
                else if (oitf_empty && ir_empty) state_nxt = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                req = ~ir_rs1en & ~flush_req;
                if (flush_req) state_nxt = ST_IDLE;
                else if (req)  state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                tk  = 1'b1;
                op1 = xn_q;
                imm = cap_imm;
                if (flush_req) begin
                    state_nxt = ST_IDLE;
                end else if (data_ph) begin
                    rdy       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    e203_ifu_jalr_sched_add u_add (
        .op1 (op1),
        .imm (imm),
        .sum (sum)
    );

    // outputs are quiet outside a completed prediction and while in reset
    assign f_ready    = rdy & rst_n;
    assign prdt_taken = f_ready & tk;
    assign prdt_pc    = f_ready ? sum : 32'd0;
    assign rf_rd_req  = req & rst_n;
    assign rf_rd_idx  = (rst_n && state == ST_RD_REQ) ? cap_rs1 : 5'd0;

    // FSM state, operand capture on leaving IDLE, rdata capture in RD_DATA
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cap_rs1 <= 5'd0;
            cap_imm <= 32'd0;
            xn_q    <= 32'd0;
            data_ph <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt != ST_IDLE) begin
                cap_rs1 <= dec_jalr_rs1idx;
                cap_imm <= dec_bjp_imm;
            end
            if (state == ST_RD_DATA && state_nxt == ST_RD_DATA && !data_ph) begin
                xn_q    <= rf_xn_rdata;
                data_ph <= 1'b1;
            end else begin
                data_ph <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_e203_ifu_jalr_sched.sv
// Scoreboard bench for e203_ifu_jalr_sched: stimulus pushes the predicted
// {taken,pc} for each instruction; a monitor pops on f_ready and compares.
module tb_e203_ifu_jalr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_valid, f_ready;
    logic [31:0] f_pc;
    logic        dec_bjp, dec_jal, dec_jalr, dec_bxx;
    logic [4:0]  dec_jalr_rs1idx;
    logic [31:0] dec_bjp_imm;
    logic        oitf_empty, ir_empty, ir_rdwen, ir_rs1en;
    logic [4:0]  ir_rdidx;
    logic [31:0] rf_x1, rf_xn_rdata;
    logic        rf_rd_req;
    logic [4:0]  rf_rd_idx;
    logic        prdt_taken;
    logic [31:0] prdt_pc;
    logic        flush_req;

    always #5 clk = ~clk;

    e203_ifu_jalr_sched dut (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_ready(f_ready),
        .f_pc(f_pc), .dec_bjp(dec_bjp), .dec_jal(dec_jal), .dec_jalr(dec_jalr),
        .dec_bxx(dec_bxx), .dec_jalr_rs1idx(dec_jalr_rs1idx),
        .dec_bjp_imm(dec_bjp_imm), .oitf_empty(oitf_empty), .ir_empty(ir_empty),
        .ir_rdwen(ir_rdwen), .ir_rdidx(ir_rdidx), .ir_rs1en(ir_rs1en),
        .rf_x1(rf_x1), .rf_xn_rdata(rf_xn_rdata), .rf_rd_req(rf_rd_req),
        .rf_rd_idx(rf_rd_idx), .prdt_taken(prdt_taken), .prdt_pc(prdt_pc),
        .flush_req(flush_req)
    );

    // kind: 0 non-bjp, 1 jal, 2 bxx, 3 jalr x0, 4 jalr x1, 5 jalr xN
    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [31:0] x1;
        logic [31:0] xn;
    } insn_t;

    logic [32:0] exp_q[$];
    logic [4:0]  exp_idx;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // reference prediction straight from the architectural rules
    function automatic logic [32:0] model(input insn_t i);
        case (i.kind)
            0: return {1'b0, i.pc + i.imm};
            1: return {1'b1, i.pc + i.imm};
`ifdef E203_IFU_BTFN_EN
            2: return i.imm[31] ? {1'b1, i.pc + i.imm} : {1'b0, i.pc + 32'd4};
`else
            2: return {1'b0, i.pc + 32'd4};
`endif
            3: return {1'b1, i.imm};
            4: return {1'b1, i.x1 + i.imm};
            default: return {1'b1, i.xn + i.imm};
        endcase
    endfunction

    function automatic insn_t rand_insn();
        insn_t i;
        i.kind = int'($urandom_range(0, 5));
        i.pc   = $urandom;
        i.imm  = $urandom;
        i.x1   = $urandom;
        i.xn   = $urandom;
        case (i.kind)
            3:       i.rs1 = 5'd0;
            4:       i.rs1 = 5'd1;
            5:       i.rs1 = 5'($urandom_range(2, 31));
            default: i.rs1 = 5'($urandom);
        endcase
        return i;
    endfunction

    task automatic drive_dec(input insn_t i);
        f_valid         = 1'b1;
        f_pc            = i.pc;
        dec_bjp         = (i.kind != 0);
        dec_jal         = (i.kind == 1);
        dec_bxx         = (i.kind == 2);
        dec_jalr        = (i.kind >= 3);
        dec_jalr_rs1idx = i.rs1;
        dec_bjp_imm     = i.imm;
    endtask

    task automatic drive_garbage();
        f_valid         = 1'($urandom_range(0, 1));
        f_pc            = $urandom;
        dec_bjp         = 1'($urandom_range(0, 1));
        dec_jal         = 1'($urandom_range(0, 1));
        dec_bxx         = 1'($urandom_range(0, 1));
        dec_jalr        = 1'($urandom_range(0, 1));
        dec_jalr_rs1idx = 5'($urandom);
        dec_bjp_imm     = $urandom;
    endtask

    // mode 0: random env+flush; 1: x1 hazard 3 cycles; 2: xN drain/stall; 3: mode 2 + flush at grant
    task automatic run_insn(input insn_t ins, input int mode, output int lat, output int nreq);
        logic prev_req;
        exp_q.push_back(model(ins));
        exp_idx  = ins.rs1;
        lat      = -1;
        nreq     = 0;
        prev_req = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 0) drive_dec(ins);
            else        drive_garbage();
            rf_x1       = ins.x1;
            rf_xn_rdata = prev_req ? ins.xn : $urandom;
            case (mode)
                0: begin
                    oitf_empty = ($urandom_range(0, 2) != 0);
                    ir_empty   = ($urandom_range(0, 2) != 0);
                    ir_rdwen   = 1'($urandom_range(0, 1));
                    ir_rdidx   = 5'($urandom_range(0, 3));
                    ir_rs1en   = ($urandom_range(0, 2) == 0);
                end
                1: begin
                    oitf_empty = 1'b1; ir_empty = 1'b1; ir_rs1en = 1'b0;
                    ir_rdwen   = (c < 3); ir_rdidx = 5'd1;
                end
                default: begin
                    oitf_empty = (c >= 2); ir_empty = 1'b1; ir_rdwen = 1'b0;
                    ir_rdidx   = 5'd0; ir_rs1en = (c == 3);
                end
            endcase
            flush_req = (mode == 0 && c > 0 && $urandom_range(0, 19) == 0) ||
                        (mode == 3 && c == 4) || (c == 40);
            #1;
            prev_req = rf_rd_req;
            if (rf_rd_req) nreq++;
            if (mode == 3 && c == 4) chk("flush_at_grant_req", 32'(rf_rd_req), 32'd0);
            if (flush_req) begin
                if (c == 40) chk("timeout_no_f_ready", 32'(c), 32'd0);
                if (exp_q.size() > 0) void'(exp_q.pop_back());
                break;
            end
            if (f_ready) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        f_valid = 1'b0; flush_req = 1'b0; dec_bjp = 1'b0; dec_jal = 1'b0;
        dec_jalr = 1'b0; dec_bxx = 1'b0;
    endtask

    // monitor: check every presented prediction and every port claim
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (f_ready && rf_rd_req) chk("ready_and_req_exclusive", 32'd1, 32'd0);
                if (rf_rd_req) chk("rf_rd_idx", 32'(rf_rd_idx), 32'(exp_idx));
                if (f_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_f_ready", 32'(f_ready), 32'd0);
                    end else begin
                        logic [32:0] e;
                        e = exp_q.pop_front();
                        chk("prdt_taken", 32'(prdt_taken), 32'(e[32]));
                        chk("prdt_pc", prdt_pc, e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        insn_t ins;
        int lat, nreq;

        // reset with a jal on the inputs: every output must stay low
        rst_n = 1'b0; flush_req = 1'b0; oitf_empty = 1'b1; ir_empty = 1'b1;
        ir_rdwen = 1'b0; ir_rdidx = 5'd0; ir_rs1en = 1'b0;
        rf_x1 = 32'd0; rf_xn_rdata = 32'd0;
        ins = '{kind: 1, pc: 32'h100, imm: 32'h20, rs1: 5'd0, x1: 32'd0, xn: 32'd0};
        drive_dec(ins);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_f_ready", 32'(f_ready), 32'd0);
        chk("rst_prdt_pc", prdt_pc, 32'd0);
        chk("rst_rf_rd_req", 32'(rf_rd_req), 32'd0);

        // idle with f_valid low: all outputs zero
        @(negedge clk);
        rst_n = 1'b1; f_valid = 1'b0;
        #1;
        chk("idle_f_ready", 32'(f_ready), 32'd0);
        chk("idle_prdt", {prdt_taken, prdt_pc[30:0]}, 32'd0);
        chk("idle_rd", {26'd0, rf_rd_req, rf_rd_idx}, 32'd0);

        // jal resolves in the fetch cycle
        run_insn(ins, 0, lat, nreq);
        chk("jal_latency", 32'(lat), 32'd0);

        // jalr x1 blocked by IR write to x1 for 3 cycles
        ins = '{kind: 4, pc: 32'h500, imm: 32'd4, rs1: 5'd1, x1: 32'h8000, xn: 32'd0};
        run_insn(ins, 1, lat, nreq);
        chk("jalr_x1_latency", 32'(lat), 32'd3);

        // jalr x5 through the shared read port with one stall
        ins = '{kind: 5, pc: 32'h600, imm: 32'hFFFF_FFF8, rs1: 5'd5, x1: 32'd0, xn: 32'h2000};
        run_insn(ins, 2, lat, nreq);
        chk("jalr_xn_one_claim", 32'(nreq), 32'd1);
        chk("jalr_xn_completed", 32'(lat > 0), 32'd1);

        // backward bxx
        ins = '{kind: 2, pc: 32'h40, imm: 32'hFFFF_FFF0, rs1: 5'd3, x1: 32'd0, xn: 32'd0};
        run_insn(ins, 0, lat, nreq);
        chk("bxx_latency", 32'(lat), 32'd0);

        // flush in the grant cycle: no claim, no f_ready, idle next cycle
        ins = '{kind: 5, pc: 32'h700, imm: 32'd8, rs1: 5'd9, x1: 32'd0, xn: 32'h1234};
        run_insn(ins, 3, lat, nreq);
        chk("flush_no_ready", 32'(lat), 32'hFFFF_FFFF);
        ins = '{kind: 1, pc: 32'h800, imm: 32'h10, rs1: 5'd0, x1: 32'd0, xn: 32'd0};
        run_insn(ins, 0, lat, nreq);
        chk("after_flush_jal_latency", 32'(lat), 32'd0);

        // reset while waiting in DEP_XN
        ins = '{kind: 5, pc: 32'h900, imm: 32'd0, rs1: 5'd7, x1: 32'd0, xn: 32'd0};
        exp_q.push_back(model(ins));
        exp_idx = ins.rs1;
        @(negedge clk); drive_dec(ins); flush_req = 1'b0; oitf_empty = 1'b0;
        @(negedge clk); drive_garbage();
        @(negedge clk);
        rst_n = 1'b0;
        ins = '{kind: 1, pc: 32'hA00, imm: 32'h4, rs1: 5'd0, x1: 32'd0, xn: 32'd0};
        drive_dec(ins); oitf_empty = 1'b1;
        #1;
        chk("midrst_f_ready", 32'(f_ready), 32'd0);
        chk("midrst_prdt", {prdt_taken, prdt_pc[30:0]}, 32'd0);
        chk("midrst_rd", {26'd0, rf_rd_req, rf_rd_idx}, 32'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1; f_valid = 1'b0;
        run_insn(ins, 0, lat, nreq);
        chk("after_rst_jal_latency", 32'(lat), 32'd0);

        // randomized traffic with decode noise while busy and random flushes
        for (int n = 0; n < 200; n++) begin
            ins = rand_insn();
            run_insn(ins, 0, lat, nreq);
            if ($urandom_range(0, 3) == 0) go_idle();
        end

        go_idle();
        repeat (2) @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/e203_ifu_jalr_sched.md
E203_IFU_JALR_SCHED -- requirements
Module: e203_ifu_jalr_sched

Interface
REQ-001 SHALL have port clk, input, 1, the single core clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port f_valid, input, 1: the fetched instruction and its decode are valid.
REQ-004 SHALL have port f_ready, output, 1: the prediction is complete and the instruction may be consumed.
REQ-005 SHALL have port f_pc, input, 32: the PC of the fetched instruction.
REQ-006 SHALL have ports dec_bjp, dec_jal, dec_jalr and dec_bxx, input, 1 each, driven from the IFU mini-decoder.
REQ-007 SHALL have ports dec_jalr_rs1idx, input, 5, and dec_bjp_imm, input, 32.
REQ-008 SHALL have ports oitf_empty and ir_empty, input, 1 each: no outstanding long-pipe writes and the IR stage is empty.
REQ-009 SHALL have ports ir_rdwen, input, 1, and ir_rdidx, input, 5: the destination of the instruction held in IR.
REQ-010 SHALL have port ir_rs1en, input, 1: the IR instruction is using the shared RF read port this cycle.
REQ-011 SHALL have ports rf_x1, input, 32 (dedicated x1 value), and rf_xn_rdata, input, 32 (shared read port data, valid one cycle after request).
REQ-012 SHALL have ports rf_rd_req, output, 1, and rf_rd_idx, output, 5: claim of the shared read port.
REQ-013 SHALL have ports prdt_taken, output, 1, and prdt_pc, output, 32.
REQ-014 SHALL have port flush_req, input, 1: the pipeline flush aborts any pending sequence.

Function
REQ-015 States SHALL be IDLE, DEP_X1, DEP_XN, RD_REQ and RD_DATA.
REQ-016 In IDLE with f_valid and a non-bjp, jal, bxx, or jalr with rs1=x0 instruction: f_ready=1 in the same cycle; prdt_pc = op1+dec_bjp_imm (32-bit wrap), where op1 = 0 for jalr x0, else f_pc.
REQ-017 jal and jalr SHALL give prdt_taken=1; non-bjp instructions SHALL give prdt_taken=0.
REQ-018 jalr with rs1=x1: the dependency is (~oitf_empty) or (ir_rdwen and ir_rdidx==1).
  - No dependency: same-cycle result, op1=rf_x1.
  - Dependency: f_ready=0, enter DEP_X1 and hold there until the dependency clears, then return the same-cycle result.
REQ-019 jalr with any other rs1: f_ready=0, enter DEP_XN.
REQ-020 DEP_XN SHALL advance to RD_REQ when oitf_empty and ir_empty.
REQ-021 In RD_REQ, rf_rd_req SHALL equal ~ir_rs1en and rf_rd_idx SHALL equal the captured rs1idx; the port is granted when rf_rd_req=1, and the FSM then goes to RD_DATA.
REQ-022 In RD_DATA, rf_xn_rdata SHALL be registered; f_ready=1 the following cycle with op1 equal to that register; then IDLE. Minimum latency is 2 cycles after the dependency clears.
REQ-023 rs1idx, imm and pc SHALL be captured on entry to any non-IDLE state; decode inputs are ignored while busy.
REQ-024 f_ready=1 SHALL never coexist with rf_rd_req=1.
REQ-025 flush_req SHALL force IDLE next cycle from any state and deassert rf_rd_req the same cycle; flush beats grant and completion.
REQ-026 With f_valid=0, the block SHALL stay in IDLE with all outputs 0.

Reset
REQ-027 Reset SHALL force state IDLE, f_ready=0, rf_rd_req=0, rf_rd_idx=0, prdt_taken=0, prdt_pc=0 and all capture registers to 0.
REQ-028 Reset asserted mid-sequence SHALL abandon it with no port claim.

Configuration
REQ-029 With E203_IFU_BTFN_EN defined, bxx SHALL be predicted taken iff dec_bjp_imm[31]=1 (backward).
REQ-030 Without E203_IFU_BTFN_EN, bxx SHALL always give prdt_taken=0 and prdt_pc=f_pc+4.

Structure
REQ-031 State encodings, and the x0/x1 index constants, SHALL live in the shared e203 defines package.
REQ-032 The 32-bit op1+imm adder SHALL be one sub-module, e203_ifu_jalr_sched_add, shared by all paths.

Verification
REQ-033 jal, f_pc=0x100, imm=0x20 -> same cycle f_ready=1, prdt_taken=1, prdt_pc=0x120.
REQ-034 jalr x1, rf_x1=0x8000, imm=4, ir_rdwen=1, ir_rdidx=1 for 3 cycles -> f_ready=0 for 3 cycles, then prdt_pc=0x8004.
REQ-035 jalr x5, oitf_empty=0 for 2 cycles, ir_rs1en=1 for 1 cycle, rdata=0x2000, imm=-8 -> rf_rd_req with idx 5 once, then f_ready=1 with prdt_pc=0x1FF8.
REQ-036 bxx, imm=0xFFFFFFF0, f_pc=0x40 -> with the macro: taken, 0x30; without the macro: not taken, 0x44.
REQ-037 flush_req in the cycle of RD_REQ grant -> rf_rd_req=0, IDLE next cycle, no f_ready.
REQ-038 rst_n low during DEP_XN -> all outputs 0 immediately; a new jal is accepted after release.
